led_pattern_driver: RTL and testbench

Output stage between the LED PIO's 8-bit `out_port` and the board LED pins. It applies software-controlled PWM brightness, optional blinking and output polarity to the pattern the PIO holds. It is configured through its own 4-word Avalon-MM slave on the same system clock. It contains a free-running prescaler, a PWM frame counter and a blink counter.

---
 rtl/led_driver_pkg.sv | 21 ++
 rtl/led_pwm_timebase.sv | 53 +++++
 rtl/led_pattern_driver.sv | 94 +++++++++
 tb/tb_led_pattern_driver.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_driver_pkg.sv
// Shared constants for the LED pattern driver: register map, CTRL bit
// positions and register reset values.
package led_driver_pkg;

    // Register word addresses on the configuration slave
    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_DUTY     = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_BLINK    = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_INVERT   = 2;

    // Register reset values (PRESCALE reset comes from a top-level parameter)
    localparam logic [2:0]  CTRL_RST  = 3'b001;
    localparam logic [7:0]  DUTY_RST  = 8'hFF;
    localparam logic [15:0] BLINK_RST = 16'd255;

endpackage

// File: rtl/led_pwm_timebase.sv
// Timebase for the LED driver: prescaler producing a tick, an 8-bit PWM
// frame counter advanced by the tick, and a blink counter advanced once per
// frame that toggles the blink phase. A restart clears everything and
// returns the blink phase to lit.
module led_pwm_timebase
    import led_driver_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic [15:0] prescale,
    input  logic [15:0] blink,
    output logic [7:0]  pwm_cnt,
    output logic        blink_phase
);

    logic [15:0] pre_cnt;
    logic [15:0] blk_cnt;
    logic        tick;
    logic        frame_end;

    assign tick      = (pre_cnt == prescale);
    assign frame_end = tick && (pwm_cnt == 8'hFF);

    // Counter chain; restart has priority over any tick or frame end on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt     <= 16'd0;
            pwm_cnt     <= 8'd0;
            blk_cnt     <= 16'd0;
            blink_phase <= 1'b1;
        end else if (restart) begin
            pre_cnt     <= 16'd0;
            pwm_cnt     <= 8'd0;
            blk_cnt     <= 16'd0;
            blink_phase <= 1'b1;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (frame_end) begin
                if (blk_cnt >= blink) begin
                    blink_phase <= ~blink_phase;
                    blk_cnt     <= 16'd0;
                end else begin
                    blk_cnt <= blk_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/led_pattern_driver.sv
// LED output stage: takes the PIO pattern and applies PWM brightness,
// optional blinking and pin polarity. Configured through a 4-word slave
// (CTRL, DUTY, PRESCALE, BLINK); pin outputs are registered.
module led_pattern_driver
    import led_driver_pkg::*;
#(
    parameter int          NUM_LEDS     = 8,
    parameter logic [15:0] PRESCALE_RST = 16'd49,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_pattern,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led_pins
);

    logic [2:0]          ctrl;
    logic [7:0]          duty;
    logic [15:0]         prescale;
    logic [15:0]         blink;
    logic                wr_en;
    logic                restart;
    logic [7:0]          pwm_cnt;
    logic                blink_phase;
    logic                pwm_on;
    logic                show;
    logic [NUM_LEDS-1:0] lit;
    logic [NUM_LEDS-1:0] pol_mask;
    logic                unused_wdata;

    assign wr_en   = chipselect && !write_n;
    // Changing the timing registers restarts the timebase so the new period starts cleanly
    assign restart = wr_en && ((address == ADDR_PRESCALE) || (address == ADDR_BLINK));
    assign unused_wdata = ^writedata[31:16];

    // Configuration register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= CTRL_RST;
            duty     <= DUTY_RST;
            prescale <= PRESCALE_RST;
            blink    <= BLINK_RST;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL:     ctrl     <= writedata[2:0];
                ADDR_DUTY:     duty     <= writedata[7:0];
                ADDR_PRESCALE: prescale <= writedata[15:0];
                default:       blink    <= writedata[15:0];
            endcase
        end
    end

    // Zero-latency readback, independent of chipselect; unused bits read 0
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL:     readdata[2:0]  = ctrl;
            ADDR_DUTY:     readdata[7:0]  = duty;
            ADDR_PRESCALE: readdata[15:0] = prescale;
            default:       readdata[15:0] = blink;
        endcase
    end

    led_pwm_timebase u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .restart     (restart),
        .prescale    (prescale),
        .blink       (blink),
        .pwm_cnt     (pwm_cnt),
        .blink_phase (blink_phase)
    );

    // Duty FF is forced fully on; otherwise lit for the first 'duty' counts of each frame
    assign pwm_on   = (duty == 8'hFF) || (pwm_cnt < duty);
    assign show     = ctrl[CTRL_ENABLE] && pwm_on && (!ctrl[CTRL_BLINK_EN] || blink_phase);
    assign lit      = show ? led_pattern : '0;
    assign pol_mask = {NUM_LEDS{ACTIVE_LOW ^ ctrl[CTRL_INVERT]}};

    // Registered pin drive; reset leaves LEDs dark for the board polarity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_pins <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            led_pins <= lit ^ pol_mask;
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Self-checking bench for led_pattern_driver (NUM_LEDS=8, ACTIVE_LOW=1).
// Expected pin values are queued as stimulus is driven and popped after the
// clock edge that should produce them.
module tb_led_pattern_driver;

    logic        clk;
    logic        reset_n;
    logic [7:0]  led_pattern;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led_pins;

    int checks;
    int failures;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    led_pattern_driver #(
        .NUM_LEDS     (8),
        .PRESCALE_RST (16'd49),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .led_pattern (led_pattern),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .led_pins    (led_pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register write; called at posedge+1, returns at posedge+1 after the write edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] rst_vals [4];
        rst_vals[0] = 32'd1;
        rst_vals[1] = 32'hFF;
        rst_vals[2] = 32'd49;
        rst_vals[3] = 32'd255;
        reset_n     = 1'b0;
        led_pattern = 8'h00;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led_pins !== 8'hFF) begin
            failures++;
            $display("FAIL reset_pins: got %h expected %h", led_pins, 8'hFF);
        end
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            #1;
            checks++;
            if (readdata !== rst_vals[a]) begin
                failures++;
                $display("FAIL reset_readdata%0d: got %h expected %h", a, readdata, rst_vals[a]);
            end
        end
        led_pattern = 8'hA5;
        @(posedge clk);
        #1;
        checks++;
        if (led_pins !== 8'hFF) begin
            failures++;
            $display("FAIL reset_hold_pattern: got %h expected %h", led_pins, 8'hFF);
        end
        led_pattern = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (led_pins !== 8'hFF) begin
            failures++;
            $display("FAIL post_reset_dark: got %h expected %h", led_pins, 8'hFF);
        end
        led_pattern = 8'hA5;
        exp_q.push_back(8'h5A);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (led_pins !== exp) begin
            failures++;
            $display("FAIL post_reset_pattern: got %h expected %h", led_pins, exp);
        end
    endtask

    task automatic test_pwm();
        int lit_cnt;
        lit_cnt = 0;
        led_pattern = 8'hFF;
        wr(2'd1, 32'h40);
        wr(2'd2, 32'd0);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back((i < 64) ? 8'h00 : 8'hFF);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (led_pins !== exp) begin
                failures++;
                $display("FAIL pwm_cycle%0d: got %h expected %h", i, led_pins, exp);
            end
            if (led_pins == 8'h00) lit_cnt++;
        end
        checks++;
        if (lit_cnt != 64) begin
            failures++;
            $display("FAIL pwm_lit_count: got %0d expected %0d", lit_cnt, 64);
        end
    endtask

    task automatic test_duty_extremes();
        wr(2'd1, 32'h00);
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(8'hFF);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (led_pins !== exp) begin
                failures++;
                $display("FAIL duty0_cycle%0d: got %h expected %h", i, led_pins, exp);
            end
        end
        wr(2'd1, 32'hFF);
        @(posedge clk);
        #1;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(8'h00);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (led_pins !== exp) begin
                failures++;
                $display("FAIL dutyff_cycle%0d: got %h expected %h", i, led_pins, exp);
            end
        end
    endtask

    task automatic test_blink();
        wr(2'd0, 32'h3);
        wr(2'd3, 32'd1);
        for (int i = 0; i < 768; i++) begin
            exp_q.push_back((i < 512) ? 8'h00 : 8'hFF);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (led_pins !== exp) begin
                failures++;
                $display("FAIL blink_cycle%0d: got %h expected %h", i, led_pins, exp);
            end
        end
        // Rewrite BLINK while dark: write edge still dark, next clock lit
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        wr(2'd3, 32'd1);
        exp = exp_q.pop_front();
        checks++;
        if (led_pins !== exp) begin
            failures++;
            $display("FAIL blink_restart_edge: got %h expected %h", led_pins, exp);
        end
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (led_pins !== exp) begin
            failures++;
            $display("FAIL blink_restart_lit: got %h expected %h", led_pins, exp);
        end
    endtask

    task automatic test_polarity();
        logic [2:0] ctrl_seq [4];
        logic [7:0] pin_seq  [4];
        ctrl_seq[0] = 3'b001; pin_seq[0] = 8'h5A;
        ctrl_seq[1] = 3'b101; pin_seq[1] = 8'hA5;
        ctrl_seq[2] = 3'b100; pin_seq[2] = 8'h00;
        ctrl_seq[3] = 3'b000; pin_seq[3] = 8'hFF;
        led_pattern = 8'hA5;
        wr(2'd0, 32'h1);
        @(posedge clk);
        #1;
        for (int k = 1; k < 4; k++) begin
            exp_q.push_back(pin_seq[k-1]);
            exp_q.push_back(pin_seq[k]);
            wr(2'd0, {29'd0, ctrl_seq[k]});
            exp = exp_q.pop_front();
            checks++;
            if (led_pins !== exp) begin
                failures++;
                $display("FAIL polarity_write%0d: got %h expected %h", k, led_pins, exp);
            end
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (led_pins !== exp) begin
                failures++;
                $display("FAIL polarity_effect%0d: got %h expected %h", k, led_pins, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        wr(2'd0, 32'h1);
        for (int i = 0; i < 16; i++) begin
            p = 8'($urandom);
            led_pattern = p;
            exp_q.push_back(~p);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (led_pins !== exp) begin
                failures++;
                $display("FAIL b2b_pattern%0d: got %h expected %h", i, led_pins, exp);
            end
        end
    endtask

    task automatic test_readback();
        logic [31:0] rb_vals [4];
        rb_vals[0] = 32'h7;
        rb_vals[1] = 32'hFF;
        rb_vals[2] = 32'hFFFF;
        rb_vals[3] = 32'hFFFF;
        for (int a = 0; a < 4; a++) begin
            wr(a[1:0], 32'hFFFF_FFFF);
        end
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            #1;
            checks++;
            if (readdata !== rb_vals[a]) begin
                failures++;
                $display("FAIL readback%0d: got %h expected %h", a, readdata, rb_vals[a]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led_pins !== 8'hFF) begin
            failures++;
            $display("FAIL async_reset_pins: got %h expected %h", led_pins, 8'hFF);
        end
        address = 2'd3;
        #1;
        checks++;
        if (readdata !== 32'd255) begin
            failures++;
            $display("FAIL async_reset_blink: got %h expected %h", readdata, 32'd255);
        end
        address = 2'd0;
        #1;
        checks++;
        if (readdata !== 32'd1) begin
            failures++;
            $display("FAIL async_reset_ctrl: got %h expected %h", readdata, 32'd1);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pwm();
        test_duty_extremes();
        test_blink();
        test_polarity();
        test_back_to_back();
        test_readback();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
